// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit line driver.
// Line levels are packed as {dplus, dminus}.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        EOP_SE0 = 2'd2,
        EOP_J   = 2'd3
    } tx_state_t;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int DEF_EOP_SE0_BITS = 2;
    localparam int DEF_MAX_ONES     = 6;

endpackage

// File: rtl/usb_nrzi_cell.sv
// Registered NRZI level (1 = J, 0 = K) with enable and synchronous preset to J.
// level_nxt is exposed so the parent can register the line in the same edge.
module usb_nrzi_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic preset,
    input  logic data,
    output logic level,
    output logic level_nxt
);

    always_comb begin
        level_nxt = level;
        if (preset)
            level_nxt = 1'b1;
        else if (en && !data)
            level_nxt = ~level;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            level <= 1'b1;
        else
            level <= level_nxt;
    end

endmodule

// File: rtl/usb_tx_line_driver.sv
// USB full-speed transmit line driver: NRZI encoding, EOP generation,
// idle-J holding and bit-stuffing violation detection.
module usb_tx_line_driver
    import usb_tx_pkg::*;
#(
    parameter int EOP_SE0_BITS = DEF_EOP_SE0_BITS,
    parameter int MAX_ONES     = DEF_MAX_ONES
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_enable,
    input  logic tx_active,
    input  logic data_in,
    output logic dplus,
    output logic dminus,
    output logic tx_busy,
    output logic eop_done,
    output logic stuff_err
);

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    tx_state_t  state, state_nxt;
    logic [2:0] se0_cnt, se0_nxt;
    logic [2:0] ones_cnt, ones_nxt, ones_base;
    logic [1:0] line_q, line_nxt;
    logic       enc, eop_nxt, stuff_nxt;
    logic       level, level_nxt, preset;

    assign preset = (state == EOP_SE0) || (state == EOP_J);

    usb_nrzi_cell u_nrzi (
        .clk       (clk),
        .rst       (rst),
        .en        (enc),
        .preset    (preset),
        .data      (data_in),
        .level     (level),
        .level_nxt (level_nxt)
    );

    always_comb begin
        state_nxt = state;
        se0_nxt   = se0_cnt;
        ones_nxt  = ones_cnt;
        ones_base = ones_cnt;
        enc       = 1'b0;
        eop_nxt   = 1'b0;
        stuff_nxt = 1'b0;
        line_nxt  = LINE_J;

        if (shift_enable) begin
            case (state)
                IDLE: begin
                    if (tx_active) begin
                        state_nxt = SEND;
                        enc       = 1'b1;
                    end
                end
                SEND: begin
                    // A strobe with tx_active low is the first SE0 bit time, never a data bit
                    if (tx_active) begin
                        enc = 1'b1;
                    end else begin
                        state_nxt = EOP_SE0;
                        se0_nxt   = 3'd1;
                    end
                end
                EOP_SE0: begin
                    if (se0_cnt == 3'(EOP_SE0_BITS))
                        state_nxt = EOP_J;
                    else
                        se0_nxt = se0_cnt + 3'd1;
                end
                EOP_J: begin
                    state_nxt = IDLE;
                    eop_nxt   = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Run length restarts with each packet; the first bit of a packet counts
        if (enc) begin
            ones_base = (state == IDLE) ? 3'd0 : ones_cnt;
            if (!data_in) begin
                ones_nxt = 3'd0;
            end else begin
                ones_nxt  = sat_inc(ones_base);
                stuff_nxt = (ones_base == 3'(MAX_ONES));
            end
        end

        case (state_nxt)
            SEND:    line_nxt = level_nxt ? LINE_J : LINE_K;
            EOP_SE0: line_nxt = LINE_SE0;
            default: line_nxt = LINE_J;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            se0_cnt   <= 3'd0;
            ones_cnt  <= 3'd0;
            line_q    <= LINE_J;
            tx_busy   <= 1'b0;
            eop_done  <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            se0_cnt   <= se0_nxt;
            ones_cnt  <= ones_nxt;
            line_q    <= line_nxt;
            tx_busy   <= (state_nxt != IDLE);
            eop_done  <= eop_nxt;
            stuff_err <= stuff_nxt;
        end
    end

    assign dplus  = line_q[1];
    assign dminus = line_q[0];

endmodule

// File: tb/tb_usb_tx_line_driver.sv
// Directed self-checking bench for usb_tx_line_driver.
module tb_usb_tx_line_driver;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic shift_enable = 1'b0;
    logic tx_active = 1'b0;
    logic data_in = 1'b0;
    logic dplus, dminus, tx_busy, eop_done, stuff_err;

    int n_chk = 0;
    int n_err = 0;

    // Pulses captured right after the strobe edge, and one clk later
    logic eop_seen, stuff_seen, eop_after, stuff_after;

    usb_tx_line_driver dut (
        .clk          (clk),
        .rst          (rst),
        .shift_enable (shift_enable),
        .tx_active    (tx_active),
        .data_in      (data_in),
        .dplus        (dplus),
        .dminus       (dminus),
        .tx_busy      (tx_busy),
        .eop_done     (eop_done),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One strobe, then one non-strobe clk so holding is exercised too
    task automatic strobe(input logic act, input logic d);
        @(negedge clk);
        shift_enable = 1'b1;
        tx_active    = act;
        data_in      = d;
        @(negedge clk);
        shift_enable = 1'b0;
        eop_seen     = eop_done;
        stuff_seen   = stuff_err;
        @(negedge clk);
        eop_after    = eop_done;
        stuff_after  = stuff_err;
    endtask

    function automatic logic [7:0] line();
        return {6'd0, dplus, dminus};
    endfunction

    logic [1:0] sync_exp [8] = '{K, J, K, J, K, J, K, K};
    logic [7:0] sync_bits = 8'b1000_0000;  // LSB first: 0000000 then 1

    initial begin
        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_line", line(), {6'd0, J});
        chk("rst_busy", {7'd0, tx_busy}, 8'd0);
        chk("rst_pulses", {6'd0, eop_done, stuff_err}, 8'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            strobe(1'b0, 1'b0);
            chk("idle_line", line(), {6'd0, J});
            chk("idle_busy", {7'd0, tx_busy}, 8'd0);
            chk("idle_pulses", {6'd0, eop_seen, stuff_seen}, 8'd0);
        end

        // Sync field
        for (int i = 0; i < 8; i++) begin
            strobe(1'b1, sync_bits[i]);
            chk($sformatf("sync_line%0d", i), line(), {6'd0, sync_exp[i]});
            chk("sync_busy", {7'd0, tx_busy}, 8'd1);
        end

        // EOP: two SE0 bit times, one J bit time, then eop_done
        strobe(1'b0, 1'b1);
        chk("eop_se0_a", line(), {6'd0, SE0});
        chk("eop_busy_a", {7'd0, tx_busy}, 8'd1);
        strobe(1'b0, 1'b0);
        chk("eop_se0_b", line(), {6'd0, SE0});
        strobe(1'b0, 1'b0);
        chk("eop_j", line(), {6'd0, J});
        chk("eop_j_nodone", {7'd0, eop_seen}, 8'd0);
        chk("eop_j_busy", {7'd0, tx_busy}, 8'd1);
        strobe(1'b0, 1'b0);
        chk("eop_done_pulse", {7'd0, eop_seen}, 8'd1);
        chk("eop_done_once", {7'd0, eop_after}, 8'd0);
        chk("eop_idle_line", line(), {6'd0, J});
        chk("eop_busy_fall", {7'd0, tx_busy}, 8'd0);

        // Stuff violation: 0 then seven 1s, one more 1, then 0 and 1
        strobe(1'b1, 1'b0);
        chk("stf_first_k", line(), {6'd0, K});
        for (int i = 1; i <= 7; i++) begin
            strobe(1'b1, 1'b1);
            chk($sformatf("stf_hold%0d", i), line(), {6'd0, K});
            chk($sformatf("stf_err%0d", i), {7'd0, stuff_seen}, (i == 7) ? 8'd1 : 8'd0);
        end
        chk("stf_err_once", {7'd0, stuff_after}, 8'd0);
        strobe(1'b1, 1'b1);
        chk("stf_sat_nopulse", {7'd0, stuff_seen}, 8'd0);
        strobe(1'b1, 1'b0);
        chk("stf_clear_line", line(), {6'd0, J});
        chk("stf_clear_nopulse", {7'd0, stuff_seen}, 8'd0);
        strobe(1'b1, 1'b1);
        chk("stf_after_clear", {7'd0, stuff_seen}, 8'd0);
        chk("stf_after_line", line(), {6'd0, J});

        // EOP with tx_active re-asserted: ignored until IDLE
        strobe(1'b0, 1'b0);
        chk("b2b_se0_a", line(), {6'd0, SE0});
        strobe(1'b1, 1'b0);
        chk("b2b_se0_b", line(), {6'd0, SE0});
        strobe(1'b1, 1'b0);
        chk("b2b_j", line(), {6'd0, J});
        strobe(1'b1, 1'b0);
        chk("b2b_idle_line", line(), {6'd0, J});
        chk("b2b_done", {7'd0, eop_seen}, 8'd1);
        chk("b2b_idle_busy", {7'd0, tx_busy}, 8'd0);
        strobe(1'b1, 1'b0);
        chk("b2b_first_k", line(), {6'd0, K});
        chk("b2b_busy", {7'd0, tx_busy}, 8'd1);

        // Mid-packet asynchronous reset while the line is K
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_line", line(), {6'd0, J});
        chk("mrst_busy", {7'd0, tx_busy}, 8'd0);
        repeat (2) @(negedge clk);
        chk("mrst_nodone", {7'd0, eop_done}, 8'd0);
        rst = 1'b1;
        strobe(1'b0, 1'b0);
        chk("mrst_idle_line", line(), {6'd0, J});
        chk("mrst_idle_busy", {7'd0, tx_busy}, 8'd0);
        chk("mrst_idle_nodone", {7'd0, eop_seen}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/usb_tx_line_driver.md
Name: usb_tx_line_driver

Overview:
- Downstream stage of the USB transmit controller: consumes its serial `data` bit, its bit-rate strobe and its packet-active indication.
- NRZI-encodes the bit stream onto the differential pair dplus/dminus.
- Appends the End-Of-Packet sequence (SE0 bit times, then one J bit time) and holds the bus at idle J between packets.
- Checks the incoming stream for bit-stuffing violations, i.e. more than 6 consecutive 1s.

Parameters:
- EOP_SE0_BITS, 2, number of bit times SE0 is driven during EOP (legal 1..7).
- MAX_ONES, 6, longest legal run of consecutive encoded 1s before stuff_err fires.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- shift_enable  in  1  one-clk bit strobe; all bus activity advances only on clk edges where this is 1
- tx_active  in  1  high while the upstream controller has packet bits to send
- data_in  in  1  serial bit from upstream, already bit-stuffed
- dplus  out  1  registered D+ line level
- dminus  out  1  registered D- line level
- tx_busy  out  1  high from the first SEND strobe until EOP completes
- eop_done  out  1  single-clk pulse when the EOP J bit time ends
- stuff_err  out  1  single-clk pulse on an illegal run of 1s

Behaviour:
- Line encodings (full speed):
  - J = dplus 1 / dminus 0
  - K = dplus 0 / dminus 1
  - SE0 = 0 / 0
  - 1/1 is never driven.
- Reset (rst=0, async):
  - state=IDLE, line=J (dplus=1, dminus=0)
  - tx_busy=0, eop_done=0, stuff_err=0
  - ones counter=0, SE0 counter=0
- NRZI rule: data 0 toggles the line J<->K; data 1 holds the current level. The level before the first packet bit is J.
- All outputs are registered. A change decided on strobe edge N is visible from N+1 and held until the next strobe.
- IDLE:
  - Drives J.
  - Strobe with tx_active=1 -> SEND, and encodes data_in on that same strobe. No bit is dropped.
  - Otherwise stays in IDLE.
- SEND:
  - Strobe with tx_active=1 -> encode data_in and remain in SEND.
  - Strobe with tx_active=0 -> EOP_SE0: drive SE0 and load SE0 counter=1. data_in is ignored on this strobe.
  - No strobe -> hold everything.
- EOP_SE0:
  - Each strobe increments the SE0 counter.
  - When the counter reaches EOP_SE0_BITS on a strobe -> EOP_J, drive J.
  - SE0 therefore lasts exactly EOP_SE0_BITS strobes.
- EOP_J:
  - The next strobe -> IDLE, and eop_done=1 for that one clk.
  - tx_active is ignored throughout EOP_SE0 and EOP_J. A new packet starts only from IDLE, at the earliest on the strobe after eop_done.
- tx_busy is 1 in SEND, EOP_SE0 and EOP_J. Its register updates with the state register.
- Ones counter (3 bits, saturating at 7):
  - Cleared on entry to SEND and on any encoded 0.
  - Increments on each encoded 1.
  - stuff_err pulses for one clk on the strobe at which the count goes from MAX_ONES to MAX_ONES+1.
  - Further 1s do not re-pulse until the counter is cleared.
- Simultaneous events: a strobe coinciding with tx_active falling is treated as the first EOP strobe. SEND never encodes a bit with tx_active=0.
- Reset mid-packet: immediate return to J/IDLE, with no EOP emitted.

Decomposition:
- Package usb_tx_pkg:
  - state enum {IDLE, SEND, EOP_SE0, EOP_J}
  - line-level constants LINE_J, LINE_K, LINE_SE0 as 2-bit {dplus, dminus}
  - default EOP_SE0_BITS
- Sub-module usb_nrzi_cell: registered NRZI toggle with an enable and a synchronous preset to J. The parent FSM overrides its output with SE0/J during EOP.

Test Plan:
- Reset then idle: rst low for 3 clk, tx_active=0, 10 strobes -> dplus/dminus=1/0 throughout; tx_busy=0, no pulses.
- Sync field 00000001 sent on 8 strobes with tx_active=1 -> line after each strobe K,J,K,J,K,J,K,K; tx_busy rises after the first strobe.
- EOP: after the sync, tx_active=0 on the next strobe -> SE0 for exactly 2 strobes, J for 1 strobe, then eop_done high for exactly 1 clk; tx_busy falls with it.
- Stuff violation: bits 0 then seven 1s -> stuff_err pulses once, on the 7th 1; line holds constant through the run. A subsequent 0 clears the counter and there is no second pulse.
- Back-to-back packets: tx_active re-asserted during EOP_J -> ignored; the packet begins on the first strobe after IDLE entry; the first data 0 drives K.
- Mid-packet reset: assert rst during SEND with line=K -> dplus/dminus=1/0 asynchronously, state IDLE, no eop_done.
